midi_tx_arbiter: RTL and testbench

MIDI_TX_ARBITER -- requirements
Module: midi_tx_arbiter

---
 rtl/midi_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_midi_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx_arbiter.sv
// midi_tx_arbiter
//   Arbitrates realtime bytes and NUM_REQ channel-message requesters onto a
//   single MIDI transmitter. Realtime bytes win; a multi-byte channel message
//   holds a lock so that only realtime bytes may interleave with it; otherwise
//   channel requesters are served round-robin. Each byte is handed to the
//   transmitter with a SEND_PULSE-cycle start pulse, then the transmitter's
//   ready line is tracked low (busy) and back high (idle).
//
//   Optional feature: define RUNNING_STATUS_EN to suppress channel status
//   bytes (0x80-0xEF) equal to the last transmitted status (acked, not sent).
//
// Ports
//   CLOCK_25        in   system clock
//   iRST            in   synchronous active-high reset
//   rt_req/rt_data  in   realtime byte request / byte
//   rt_ack          out  one-cycle accept pulse for the realtime byte
//   ch_req          in   per-requester byte request [NUM_REQ]
//   ch_data         in   per-requester byte, requester i in [8i+7:8i]
//   ch_last         in   byte is last of its message [NUM_REQ]
//   ch_ack          out  one-cycle accept pulse per requester
//   midi_send_byte  out  start pulse to the transmitter
//   midi_out_data   out  byte to the transmitter
//   midi_out_ready  in   transmitter idle (high) / busy (low), asynchronous
//   busy            out  byte in flight or message lock held
//   grant_id        out  lock holder, else last channel winner
//   tx_timeout      out  sticky: transmitter never went busy after a send
module midi_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int SEND_PULSE = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 CLOCK_25,
  input  logic                 iRST,
  input  logic                 rt_req,
  input  logic [7:0]           rt_data,
  output logic                 rt_ack,
  input  logic [NUM_REQ-1:0]   ch_req,
  input  logic [8*NUM_REQ-1:0] ch_data,
  input  logic [NUM_REQ-1:0]   ch_last,
  output logic [NUM_REQ-1:0]   ch_ack,
  output logic                 midi_send_byte,
  output logic [7:0]           midi_out_data,
  input  logic                 midi_out_ready,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 tx_timeout
);

  localparam int CNT_MAX = (SEND_PULSE > TIMEOUT) ? SEND_PULSE : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_rdy_meta, r_rdy_sync;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_send, w_send_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_rt_ack, w_rt_ack_nxt;
  logic [NUM_REQ-1:0] r_ch_ack, w_ch_ack_nxt;
  logic               r_lock, w_lock_nxt;
  logic [1:0]         r_lock_id, w_lock_id_nxt;
  logic [1:0]         r_ptr, w_ptr_nxt;
  logic [1:0]         r_grant, w_grant_nxt;
  logic               r_timeout, w_timeout_nxt;
`ifdef RUNNING_STATUS_EN
  logic               r_rs_valid, w_rs_valid_nxt;
  logic [7:0]         r_rs, w_rs_nxt;
`endif

  logic               w_rr_found;
  logic [1:0]         w_rr_id;
  logic               w_ch_valid;
  logic [1:0]         w_ch_id;
  logic [7:0]         w_ch_byte;
  logic               w_ack_pending;
  logic               w_do_send;

  // Round-robin search starting at the pointer.
  always_comb begin
    int v_idx;
    w_rr_found = 1'b0;
    w_rr_id    = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_rr_found && ch_req[v_idx]) begin
        w_rr_found = 1'b1;
        w_rr_id    = 2'(v_idx);
      end
    end
  end

  // A held lock restricts the channel candidate to the lock holder.
  always_comb begin
    if (r_lock) begin
      w_ch_id    = r_lock_id;
      w_ch_valid = ch_req[r_lock_id];
    end else begin
      w_ch_id    = w_rr_id;
      w_ch_valid = w_rr_found;
    end
    w_ch_byte = ch_data[8*int'(w_ch_id) +: 8];
  end

  // Requesters only drop req after seeing ack, so nothing may be selected
  // while an ack is still on the wire (matters for suppressed bytes that
  // leave the FSM in IDLE).
  assign w_ack_pending = r_rt_ack | (|r_ch_ack);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_send_nxt    = r_send;
    w_data_nxt    = r_data;
    w_rt_ack_nxt  = 1'b0;
    w_ch_ack_nxt  = '0;
    w_lock_nxt    = r_lock;
    w_lock_id_nxt = r_lock_id;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_timeout_nxt = r_timeout;
    w_do_send     = 1'b0;
`ifdef RUNNING_STATUS_EN
    w_rs_valid_nxt = r_rs_valid;
    w_rs_nxt       = r_rs;
`endif
    case (r_state)
      IDLE: begin
        if (r_rdy_sync && !w_ack_pending) begin
          if (rt_req) begin
            w_rt_ack_nxt = 1'b1;
            w_data_nxt   = rt_data;
            w_do_send    = 1'b1;
          end else if (w_ch_valid) begin
            w_ch_ack_nxt[w_ch_id] = 1'b1;
            w_grant_nxt           = w_ch_id;
            if (ch_last[w_ch_id]) begin
              w_lock_nxt = 1'b0;
              w_ptr_nxt  = (int'(w_ch_id) == NUM_REQ - 1) ? 2'd0 : w_ch_id + 2'd1;
            end else begin
              w_lock_nxt    = 1'b1;
              w_lock_id_nxt = w_ch_id;
            end
            w_data_nxt = w_ch_byte;
            w_do_send  = 1'b1;
`ifdef RUNNING_STATUS_EN
            if (w_ch_byte >= 8'h80 && w_ch_byte <= 8'hEF) begin
              if (r_rs_valid && w_ch_byte == r_rs) begin
                w_data_nxt = r_data;
                w_do_send  = 1'b0;
              end else begin
                w_rs_valid_nxt = 1'b1;
                w_rs_nxt       = w_ch_byte;
              end
            end else if (w_ch_byte >= 8'hF0 && w_ch_byte <= 8'hF7) begin
              w_rs_valid_nxt = 1'b0;
            end
`endif
          end
          if (w_do_send) begin
            w_send_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (r_cnt == CNT_W'(SEND_PULSE - 1)) begin
          w_send_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_LOW;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!r_rdy_sync) begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_HIGH;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (r_rdy_sync) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      r_state    <= IDLE;
      r_rdy_meta <= 1'b0;
      r_rdy_sync <= 1'b0;
      r_cnt      <= '0;
      r_send     <= 1'b0;
      r_data     <= 8'h00;
      r_rt_ack   <= 1'b0;
      r_ch_ack   <= '0;
      r_lock     <= 1'b0;
      r_lock_id  <= 2'd0;
      r_ptr      <= 2'd0;
      r_grant    <= 2'd0;
      r_timeout  <= 1'b0;
`ifdef RUNNING_STATUS_EN
      r_rs_valid <= 1'b0;
      r_rs       <= 8'h00;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_rdy_meta <= midi_out_ready;
      r_rdy_sync <= r_rdy_meta;
      r_cnt      <= w_cnt_nxt;
      r_send     <= w_send_nxt;
      r_data     <= w_data_nxt;
      r_rt_ack   <= w_rt_ack_nxt;
      r_ch_ack   <= w_ch_ack_nxt;
      r_lock     <= w_lock_nxt;
      r_lock_id  <= w_lock_id_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_timeout  <= w_timeout_nxt;
`ifdef RUNNING_STATUS_EN
      r_rs_valid <= w_rs_valid_nxt;
      r_rs       <= w_rs_nxt;
`endif
    end
  end

  assign rt_ack         = r_rt_ack;
  assign ch_ack         = r_ch_ack;
  assign midi_send_byte = r_send;
  assign midi_out_data  = r_data;
  assign busy           = (r_state != IDLE) | r_lock;
  assign grant_id       = r_grant;
  assign tx_timeout     = r_timeout;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
module tb_midi_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int SEND_PULSE = 4;
  localparam int TIMEOUT = 1023;
  localparam int LOW_CYC = 402;

  logic                 CLOCK_25 = 1'b0;
  logic                 iRST = 1'b1;
  logic                 rt_req = 1'b0;
  logic [7:0]           rt_data = 8'h00;
  logic                 rt_ack;
  logic [NUM_REQ-1:0]   ch_req = '0;
  logic [8*NUM_REQ-1:0] ch_data = '0;
  logic [NUM_REQ-1:0]   ch_last = '0;
  logic [NUM_REQ-1:0]   ch_ack;
  logic                 midi_send_byte;
  logic [7:0]           midi_out_data;
  logic                 midi_out_ready = 1'b1;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 tx_timeout;

  midi_tx_arbiter #(.NUM_REQ(NUM_REQ), .SEND_PULSE(SEND_PULSE), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_25(CLOCK_25), .iRST(iRST),
    .rt_req(rt_req), .rt_data(rt_data), .rt_ack(rt_ack),
    .ch_req(ch_req), .ch_data(ch_data), .ch_last(ch_last), .ch_ack(ch_ack),
    .midi_send_byte(midi_send_byte), .midi_out_data(midi_out_data),
    .midi_out_ready(midi_out_ready), .busy(busy), .grant_id(grant_id),
    .tx_timeout(tx_timeout)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int  ack_cnt[NUM_REQ];
  bit  stuck_high = 0;
  bit  chk_stable = 1;
  bit  m_active = 0;
  bit  m_prev = 0;
  int  m_unstable = 0;
  bit  mon_busy = 0;
  int  busy_gaps = 0;
  bit  hit_3c = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: on each start pulse, pop the scoreboard, then go busy
  // (ready low) for LOW_CYC cycles unless told to stay stuck high.
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge CLOCK_25);
      if (midi_send_byte && !m_prev) begin
        got = midi_out_data;
        m_active = 1;
        if (exp_q.size() == 0) check("sb_extra", {24'h0, got}, 32'h100);
        else check("tx_byte", {24'h0, got}, {24'h0, exp_q.pop_front()});
        if (!stuck_high) begin
          repeat (2) @(negedge CLOCK_25);
          midi_out_ready = 0;
          repeat (LOW_CYC) begin
            @(negedge CLOCK_25);
            if (chk_stable && midi_out_data != got) m_unstable++;
          end
          midi_out_ready = 1;
        end
        m_active = 0;
      end
      m_prev = midi_send_byte;
    end
  end

  always @(negedge CLOCK_25)
    if (mon_busy && !busy) busy_gaps++;

  task automatic do_reset();
    iRST = 1;
    repeat (2) @(posedge CLOCK_25);
    #1;
    iRST = 0;
    for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
  endtask

  task automatic ch_byte(input int r, input logic [7:0] b, input logic last);
    int n;
    ch_data[8*r +: 8] = b;
    ch_last[r] = last;
    ch_req[r] = 1;
    n = 0;
    do begin
      @(posedge CLOCK_25);
      #1;
      n++;
    end while (!ch_ack[r] && n < 5000);
    check("ch_ack_seen", {31'h0, ch_ack[r]}, 32'h1);
    check("grant_id", {30'h0, grant_id}, r);
    ch_req[r] = 0;
    ack_cnt[r]++;
  endtask

  task automatic rt_byte(input logic [7:0] b);
    int n;
    rt_data = b;
    rt_req = 1;
    n = 0;
    do begin
      @(posedge CLOCK_25);
      #1;
      n++;
    end while (!rt_ack && n < 5000);
    check("rt_ack_seen", {31'h0, rt_ack}, 32'h1);
    rt_req = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy == 0 && !m_active && midi_out_ready) && n < 4000) begin
      @(posedge CLOCK_25);
      #1;
      n++;
    end
    check("idle_reached", {31'h0, n < 4000}, 32'h1);
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset values
    do_reset();
    check("rst_send", {31'h0, midi_send_byte}, 0);
    check("rst_data", {24'h0, midi_out_data}, 0);
    check("rst_rt_ack", {31'h0, rt_ack}, 0);
    check("rst_ch_ack", {30'h0, ch_ack}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_grant", {30'h0, grant_id}, 0);
    check("rst_timeout", {31'h0, tx_timeout}, 0);

    // Three-byte note-on with busy held across the whole message
    do_reset();
    m_unstable = 0;
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    busy_gaps = 0;
    ch_byte(0, 8'h90, 0);
    mon_busy = 1;
    ch_byte(0, 8'h3C, 0);
    ch_byte(0, 8'h64, 1);
    mon_busy = 0;
    wait_idle();
    check("msg_acks", ack_cnt[0], 3);
    check("busy_held", busy_gaps, 0);
    check("data_stable", m_unstable, 0);

    // Realtime byte interleaved into a locked message; requester 1 waits
    do_reset();
    hit_3c = 0;
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'hF8);
    exp_q.push_back(8'h64); exp_q.push_back(8'h55);
    fork
      begin
        ch_byte(0, 8'h90, 0);
        ch_byte(0, 8'h3C, 0);
        hit_3c = 1;
        ch_byte(0, 8'h64, 1);
      end
      begin
        wait (hit_3c);
        rt_byte(8'hF8);
        check("rt_lock_kept", {31'h0, busy}, 1);
        check("rt_lock_id", {30'h0, grant_id}, 0);
      end
      ch_byte(1, 8'h55, 1);
    join
    wait_idle();

    // Round-robin between two single-byte requesters
    do_reset();
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    fork
      begin ch_byte(0, 8'h10, 1); ch_byte(0, 8'h11, 1); end
      begin ch_byte(1, 8'h20, 1); ch_byte(1, 8'h21, 1); end
    join
    wait_idle();

    // Transmitter never goes busy: timeout, then recovery
    do_reset();
    stuck_high = 1;
    exp_q.push_back(8'h42);
    ch_byte(0, 8'h42, 1);
    n = 0;
    while (!tx_timeout && n < 1500) begin
      @(posedge CLOCK_25);
      #1;
      n++;
    end
    check("timeout_cycles", n, SEND_PULSE + TIMEOUT);
    check("timeout_flag", {31'h0, tx_timeout}, 1);
    check("timeout_idle", {31'h0, busy}, 0);
    stuck_high = 0;
    exp_q.push_back(8'h43);
    ch_byte(0, 8'h43, 1);
    wait_idle();
    check("timeout_sticky", {31'h0, tx_timeout}, 1);

    // Repeated status byte: suppressed with running status, sent without
    do_reset();
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
`ifndef RUNNING_STATUS_EN
    exp_q.push_back(8'h90);
`endif
    exp_q.push_back(8'h3E); exp_q.push_back(8'h64);
    ch_byte(0, 8'h90, 0);
    ch_byte(0, 8'h3C, 0);
    ch_byte(0, 8'h64, 1);
    ch_byte(0, 8'h90, 0);
    ch_byte(0, 8'h3E, 0);
    ch_byte(0, 8'h64, 1);
    wait_idle();
    check("rs_acks", ack_cnt[0], 6);

    // Reset during SEND aborts the pulse
    do_reset();
    chk_stable = 0;
    exp_q.push_back(8'h77);
    ch_byte(0, 8'h77, 1);
    check("send_up", {31'h0, midi_send_byte}, 1);
    iRST = 1;
    @(posedge CLOCK_25);
    #1;
    check("abort_send", {31'h0, midi_send_byte}, 0);
    check("abort_data", {24'h0, midi_out_data}, 0);
    check("abort_ch_ack", {30'h0, ch_ack}, 0);
    check("abort_rt_ack", {31'h0, rt_ack}, 0);
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_grant", {30'h0, grant_id}, 0);
    iRST = 0;
    repeat (3) @(posedge CLOCK_25);
    #1;
    check("abort_no_resend", {31'h0, midi_send_byte}, 0);
    wait_idle();
    chk_stable = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
